// File: rtl/id_ex_ctrl.sv
// MIPS ID-stage control: decodes the IF/ID instruction into the ID/EX control bundle,
// detects load-use hazards, inserts bubbles and counts illegal opcodes.
module id_ex_ctrl #(
    parameter int unsigned ALU_OP_W   = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           instr_i,
    input  logic                  id_valid_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic                  ex_reg_write_o,
    output logic [ALU_OP_W-1:0]   ex_alu_op_o,
    output logic                  ex_alu_src_o,
    output logic [1:0]            ex_reg_dst_o,
    output logic [REG_ADDR_W-1:0] ex_write_reg_o,
    output logic                  ex_branch_o,
    output logic [1:0]            ex_branch_type_o,
    output logic [1:0]            ex_jump_o,
    output logic [1:0]            ex_mem_to_reg_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  illegal_o,
    output logic [CNT_W-1:0]      ill_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  unused_shamt;

    assign opcode       = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign rs           = REG_ADDR_W'(instr_i[25:21]);
    assign rt           = REG_ADDR_W'(instr_i[20:16]);
    assign rd           = REG_ADDR_W'(instr_i[15:11]);
    assign unused_shamt = ^instr_i[10:6];

    logic                  d_reg_write;
    logic [ALU_OP_W-1:0]   d_alu_op;
    logic                  d_alu_src;
    logic [1:0]            d_reg_dst;
    logic [REG_ADDR_W-1:0] d_write_reg;
    logic                  d_branch;
    logic [1:0]            d_branch_type;
    logic [1:0]            d_jump;
    logic [1:0]            d_mem_to_reg;
    logic                  d_mem_read;
    logic                  d_mem_write;
    logic                  d_illegal;
    logic                  uses_rt;

    // Instruction decode; unused fields stay 0
    always_comb begin
        d_reg_write   = 1'b0;
        d_alu_op      = '0;
        d_alu_src     = 1'b0;
        d_reg_dst     = 2'd0;
        d_branch      = 1'b0;
        d_branch_type = 2'd0;
        d_jump        = 2'd0;
        d_mem_to_reg  = 2'd0;
        d_mem_read    = 1'b0;
        d_mem_write   = 1'b0;
        d_illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    6'd32, 6'd34, 6'd36, 6'd37, 6'd42: begin
                        d_reg_write = 1'b1;
                        d_reg_dst   = 2'd1;
                    end
                    6'd8:    d_jump    = 2'd2;
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_BEQ: begin
                d_alu_op = ALU_OP_W'(2);
                d_branch = 1'b1;
            end
            OP_BNE: begin
                d_alu_op      = ALU_OP_W'(3);
                d_branch      = 1'b1;
                d_branch_type = 2'd3;
            end
            OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                case (opcode)
                    OP_ADDI: d_alu_op = ALU_OP_W'(6);
                    OP_SLTI: d_alu_op = ALU_OP_W'(11);
                    OP_ORI:  d_alu_op = ALU_OP_W'(7);
                    default: d_alu_op = ALU_OP_W'(8);
                endcase
            end
            OP_LW: begin
                d_reg_write  = 1'b1;
                d_alu_op     = ALU_OP_W'(9);
                d_alu_src    = 1'b1;
                d_mem_to_reg = 2'd1;
                d_mem_read   = 1'b1;
            end
            OP_SW: begin
                d_alu_op    = ALU_OP_W'(10);
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
            end
            OP_J:    d_jump = 2'd1;
            OP_JAL: begin
                d_reg_write  = 1'b1;
                d_alu_op     = ALU_OP_W'(12);
                d_reg_dst    = 2'd2;
                d_mem_to_reg = 2'd2;
                d_jump       = 2'd1;
            end
            default: d_illegal = 1'b1;
        endcase

        case (d_reg_dst)
            2'd1:    d_write_reg = rd;
            2'd2:    d_write_reg = REG_ADDR_W'(31);
            default: d_write_reg = rt;
        endcase
        if (d_write_reg == '0) d_reg_write = 1'b0;
    end

    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE) || (opcode == OP_SW);

    // Load-use hazard against the load currently in EX
    assign stall_o = id_valid_i && !flush_i && ex_valid_o && ex_mem_read_o &&
                     (ex_write_reg_o != '0) &&
                     ((ex_write_reg_o == rs) || (uses_rt && (ex_write_reg_o == rt)));

    logic bubble_c;
    logic load_c;

    assign bubble_c = flush_i || stall_o || !id_valid_i;
    assign load_c   = !bubble_c && !d_illegal;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_valid_o       <= 1'b0;
            ex_reg_write_o   <= 1'b0;
            ex_alu_op_o      <= '0;
            ex_alu_src_o     <= 1'b0;
            ex_reg_dst_o     <= 2'd0;
            ex_write_reg_o   <= '0;
            ex_branch_o      <= 1'b0;
            ex_branch_type_o <= 2'd0;
            ex_jump_o        <= 2'd0;
            ex_mem_to_reg_o  <= 2'd0;
            ex_mem_read_o    <= 1'b0;
            ex_mem_write_o   <= 1'b0;
            illegal_o        <= 1'b0;
            ill_cnt_o        <= '0;
        end else begin
            ex_valid_o       <= load_c;
            ex_reg_write_o   <= load_c ? d_reg_write   : 1'b0;
            ex_alu_op_o      <= load_c ? d_alu_op      : '0;
            ex_alu_src_o     <= load_c ? d_alu_src     : 1'b0;
            ex_reg_dst_o     <= load_c ? d_reg_dst     : 2'd0;
            ex_write_reg_o   <= load_c ? d_write_reg   : '0;
            ex_branch_o      <= load_c ? d_branch      : 1'b0;
            ex_branch_type_o <= load_c ? d_branch_type : 2'd0;
            ex_jump_o        <= load_c ? d_jump        : 2'd0;
            ex_mem_to_reg_o  <= load_c ? d_mem_to_reg  : 2'd0;
            ex_mem_read_o    <= load_c ? d_mem_read    : 1'b0;
            ex_mem_write_o   <= load_c ? d_mem_write   : 1'b0;
            illegal_o        <= !bubble_c && d_illegal;
            // Counter saturates at all-ones
            if (!bubble_c && d_illegal && (ill_cnt_o != '1))
                ill_cnt_o <= ill_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Directed bench for id_ex_ctrl: a reference decoder pushes the expected ID/EX bundle
// into a queue when an instruction is driven; it is popped and compared after the edge.
module tb_id_ex_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        id_valid;
    logic        flush;

    logic        stall, ex_valid, ex_rw, ex_src, ex_br, ex_mr, ex_mw, ill;
    logic [3:0]  ex_op;
    logic [1:0]  ex_dst, ex_bt, ex_jmp, ex_m2r;
    logic [4:0]  ex_wr;
    logic [7:0]  cnt;

    logic        stall2, ex_valid2, ex_rw2, ex_src2, ex_br2, ex_mr2, ex_mw2, ill2;
    logic [3:0]  ex_op2;
    logic [1:0]  ex_dst2, ex_bt2, ex_jmp2, ex_m2r2;
    logic [4:0]  ex_wr2;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    id_ex_ctrl dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .id_valid_i(id_valid), .flush_i(flush),
        .stall_o(stall), .ex_valid_o(ex_valid), .ex_reg_write_o(ex_rw), .ex_alu_op_o(ex_op),
        .ex_alu_src_o(ex_src), .ex_reg_dst_o(ex_dst), .ex_write_reg_o(ex_wr),
        .ex_branch_o(ex_br), .ex_branch_type_o(ex_bt), .ex_jump_o(ex_jmp),
        .ex_mem_to_reg_o(ex_m2r), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
        .illegal_o(ill), .ill_cnt_o(cnt)
    );

    id_ex_ctrl #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .id_valid_i(id_valid), .flush_i(flush),
        .stall_o(stall2), .ex_valid_o(ex_valid2), .ex_reg_write_o(ex_rw2), .ex_alu_op_o(ex_op2),
        .ex_alu_src_o(ex_src2), .ex_reg_dst_o(ex_dst2), .ex_write_reg_o(ex_wr2),
        .ex_branch_o(ex_br2), .ex_branch_type_o(ex_bt2), .ex_jump_o(ex_jmp2),
        .ex_mem_to_reg_o(ex_m2r2), .ex_mem_read_o(ex_mr2), .ex_mem_write_o(ex_mw2),
        .illegal_o(ill2), .ill_cnt_o(cnt2)
    );

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic [3:0] op;
        logic       src;
        logic [1:0] dst;
        logic [4:0] wr;
        logic       br;
        logic [1:0] bt;
        logic [1:0] jmp;
        logic [1:0] m2r;
        logic       mr;
        logic       mw;
        logic       ill;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         exp_cnt = 0;
    int         exp_cnt2 = 0;

    function automatic logic [31:0] rt_ins(input int fn, input int rs_a, input int rt_a, input int rd_a);
        return {6'd0, 5'(rs_a), 5'(rt_a), 5'(rd_a), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs_a, input int rt_a, input int imm);
        return {6'(op), 5'(rs_a), 5'(rt_a), 16'(imm)};
    endfunction

    // Reference decode table
    function automatic exp_t ref_dec(input logic [31:0] w, output logic bad);
        exp_t e;
        logic [5:0] op_f;
        logic [5:0] fn_f;
        e = '0;
        bad = 1'b0;
        op_f = w[31:26];
        fn_f = w[5:0];
        e.valid = 1'b1;
        if (op_f == 6'd0) begin
            if (fn_f == 6'd32 || fn_f == 6'd34 || fn_f == 6'd36 || fn_f == 6'd37 || fn_f == 6'd42) begin
                e.rw = 1'b1; e.dst = 2'd1;
            end else if (fn_f == 6'd8) e.jmp = 2'd2;
            else bad = 1'b1;
        end else if (op_f == 6'd4) begin e.op = 4'd2; e.br = 1'b1; end
        else if (op_f == 6'd5) begin e.op = 4'd3; e.br = 1'b1; e.bt = 2'd3; end
        else if (op_f == 6'd8) begin e.op = 4'd6; e.src = 1'b1; e.rw = 1'b1; end
        else if (op_f == 6'd10) begin e.op = 4'd11; e.src = 1'b1; e.rw = 1'b1; end
        else if (op_f == 6'd13) begin e.op = 4'd7; e.src = 1'b1; e.rw = 1'b1; end
        else if (op_f == 6'd15) begin e.op = 4'd8; e.src = 1'b1; e.rw = 1'b1; end
        else if (op_f == 6'd35) begin e.op = 4'd9; e.src = 1'b1; e.rw = 1'b1; e.m2r = 2'd1; e.mr = 1'b1; end
        else if (op_f == 6'd43) begin e.op = 4'd10; e.src = 1'b1; e.mw = 1'b1; end
        else if (op_f == 6'd2) e.jmp = 2'd1;
        else if (op_f == 6'd3) begin e.op = 4'd12; e.dst = 2'd2; e.m2r = 2'd2; e.rw = 1'b1; e.jmp = 2'd1; end
        else bad = 1'b1;
        e.wr = (e.dst == 2'd1) ? w[15:11] : (e.dst == 2'd2) ? 5'd31 : w[20:16];
        if (e.wr == 5'd0) e.rw = 1'b0;
        if (bad) e = '0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cmp_bundle(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
        chk({tag, ".reg_write"}, 32'(ex_rw), 32'(e.rw));
        chk({tag, ".alu_op"}, 32'(ex_op), 32'(e.op));
        chk({tag, ".alu_src"}, 32'(ex_src), 32'(e.src));
        chk({tag, ".reg_dst"}, 32'(ex_dst), 32'(e.dst));
        chk({tag, ".write_reg"}, 32'(ex_wr), 32'(e.wr));
        chk({tag, ".branch"}, 32'(ex_br), 32'(e.br));
        chk({tag, ".branch_type"}, 32'(ex_bt), 32'(e.bt));
        chk({tag, ".jump"}, 32'(ex_jmp), 32'(e.jmp));
        chk({tag, ".mem_to_reg"}, 32'(ex_m2r), 32'(e.m2r));
        chk({tag, ".mem_read"}, 32'(ex_mr), 32'(e.mr));
        chk({tag, ".mem_write"}, 32'(ex_mw), 32'(e.mw));
        chk({tag, ".illegal"}, 32'(ill), 32'(e.ill));
        chk({tag, ".ill_cnt"}, 32'(cnt), 32'(e.cnt));
    endtask

    // Drive one instruction, check the combinational stall, then the registered bundle
    task automatic step(input string tag, input logic [31:0] w, input logic v, input logic fl,
                        input logic exp_stall);
        exp_t e;
        logic bad;
        instr = w; id_valid = v; flush = fl;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        e = ref_dec(w, bad);
        if (fl || exp_stall || !v) e = '0;
        else if (bad) begin
            e = '0;
            e.ill = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        e.cnt = 8'(exp_cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmp_bundle(tag);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; id_valid = 1'b1;
        instr = i_ins(8, 1, 9, 5);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("rst.valid", 32'(ex_valid), 32'd0);
            chk("rst.alu_op", 32'(ex_op), 32'd0);
            chk("rst.reg_write", 32'(ex_rw), 32'd0);
            chk("rst.write_reg", 32'(ex_wr), 32'd0);
            chk("rst.ill_cnt", 32'(cnt), 32'd0);
            chk("rst.stall", 32'(stall), 32'd0);
        end
        rst = 1'b1;
        step("addi_after_rst", i_ins(8, 1, 9, 5), 1'b1, 1'b0, 1'b0);
        chk("addi_after_rst.op6_src1_rt9", {ex_op, 3'd0, ex_src, ex_wr}, {4'd6, 3'd0, 1'b1, 5'd9});

        // Decode sweep of every legal opcode / funct
        step("add",  rt_ins(32, 1, 2, 3), 1'b1, 1'b0, 1'b0);
        step("sub",  rt_ins(34, 1, 2, 4), 1'b1, 1'b0, 1'b0);
        step("and",  rt_ins(36, 1, 2, 5), 1'b1, 1'b0, 1'b0);
        step("or",   rt_ins(37, 1, 2, 6), 1'b1, 1'b0, 1'b0);
        step("slt",  rt_ins(42, 1, 2, 7), 1'b1, 1'b0, 1'b0);
        step("jr",   rt_ins(8, 31, 0, 0), 1'b1, 1'b0, 1'b0);
        step("beq",  i_ins(4, 1, 2, 16), 1'b1, 1'b0, 1'b0);
        step("bne",  i_ins(5, 3, 4, 8), 1'b1, 1'b0, 1'b0);
        step("addi", i_ins(8, 1, 10, 100), 1'b1, 1'b0, 1'b0);
        step("slti", i_ins(10, 2, 11, 7), 1'b1, 1'b0, 1'b0);
        step("ori",  i_ins(13, 3, 12, 255), 1'b1, 1'b0, 1'b0);
        step("lui",  i_ins(15, 0, 13, 4660), 1'b1, 1'b0, 1'b0);
        step("lw",   i_ins(35, 1, 20, 4), 1'b1, 1'b0, 1'b0);
        step("sw",   i_ins(43, 1, 2, 8), 1'b1, 1'b0, 1'b0);
        step("j",    {6'd2, 26'h0000100}, 1'b1, 1'b0, 1'b0);
        step("jal",  {6'd3, 26'h0000200}, 1'b1, 1'b0, 1'b0);
        chk("jal.wr31_m2r2", {ex_wr, ex_m2r}, {5'd31, 2'd2});

        // Load-use: one stall cycle, bubble, then the held ADD issues
        step("lu.lw8",     i_ins(35, 1, 8, 0), 1'b1, 1'b0, 1'b0);
        step("lu.add_stl", rt_ins(32, 8, 2, 9), 1'b1, 1'b0, 1'b1);
        step("lu.add_go",  rt_ins(32, 8, 2, 9), 1'b1, 1'b0, 1'b0);
        step("lu.lw0",     i_ins(35, 1, 0, 0), 1'b1, 1'b0, 1'b0);
        step("lu.add_r0",  rt_ins(32, 0, 2, 9), 1'b1, 1'b0, 1'b0);
        step("lu.lw8_rt",  i_ins(35, 1, 8, 0), 1'b1, 1'b0, 1'b0);
        step("lu.sw_rt8",  i_ins(43, 1, 8, 0), 1'b1, 1'b0, 1'b1);

        // Flush beats a load-use condition
        step("fl.lw8",  i_ins(35, 1, 8, 0), 1'b1, 1'b0, 1'b0);
        step("fl.add",  rt_ins(32, 8, 2, 9), 1'b1, 1'b1, 1'b0);
        step("idle",    i_ins(8, 1, 9, 5), 1'b0, 1'b0, 1'b0);

        // Illegal opcodes, including flush/invalid masking
        step("ill.op63",  i_ins(63, 1, 2, 3), 1'b1, 1'b0, 1'b0);
        step("ill.fn0",   rt_ins(0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        chk("ill.cnt2", 32'(cnt), 32'd2);
        step("ill.flush", i_ins(63, 1, 2, 3), 1'b1, 1'b1, 1'b0);
        step("ill.inval", i_ins(63, 1, 2, 3), 1'b0, 1'b0, 1'b0);
        step("ill.3",     i_ins(1, 1, 2, 3), 1'b1, 1'b0, 1'b0);
        step("ill.4",     rt_ins(9, 1, 2, 3), 1'b1, 1'b0, 1'b0);
        step("ill.5",     i_ins(40, 1, 2, 3), 1'b1, 1'b0, 1'b0);
        chk("ill.cnt5", 32'(cnt), 32'd5);
        chk("ill.cnt_w2_sat", 32'(cnt2), 32'(exp_cnt2));

        // Write to $0 is valid but does not write
        step("addi_r0", i_ins(8, 1, 0, 5), 1'b1, 1'b0, 1'b0);
        chk("addi_r0.rw0_v1", {ex_rw, ex_valid}, {1'b0, 1'b1});

        // Reset asserted during a stall
        step("rs.lw8", i_ins(35, 1, 8, 0), 1'b1, 1'b0, 1'b0);
        instr = rt_ins(32, 8, 2, 9);
        rst = 1'b0;
        #1;
        chk("rs.stall_pre", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        chk("rs.valid", 32'(ex_valid), 32'd0);
        chk("rs.stall", 32'(stall), 32'd0);
        chk("rs.ill_cnt", 32'(cnt), 32'd0);
        chk("rs.ill_cnt2", 32'(cnt2), 32'd0);
        rst = 1'b1;
        exp_cnt = 0;
        exp_cnt2 = 0;
        step("rs.add_after", rt_ins(32, 8, 2, 9), 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
